// File: rtl/lsu_io_req_queue.sv
// ============================================================================
//  Module      : lsu_io_req_queue
//  Description : In-order queue of uncached/IO loads, stores and fences
//                between the LSQ and the LSU bus controller. Fences retire
//                locally once no IO request is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_io_req_queue #(
    parameter int DEPTH              = 4,
    parameter int ROB_INDEX_WIDTH    = 6,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int STU_OP_WIDTH       = 5,
    parameter int PHYSICAL_ADDR_LEN  = 56,
    parameter int XLEN               = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    // enqueue side (LSQ)
    input  logic                          lsq_io_q_req_vld_i,
    output logic                          io_q_lsq_rdy_o,
    input  logic                          lsq_io_q_req_load_or_store_i,
    input  logic                          lsq_io_q_req_is_fence_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    lsq_io_q_req_rob_index_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsq_io_q_req_rd_addr_i,
    input  logic [STU_OP_WIDTH-1:0]       lsq_io_q_req_opcode_i,
    input  logic [PHYSICAL_ADDR_LEN-1:0]  lsq_io_q_req_paddr_i,
    input  logic [XLEN-1:0]               lsq_io_q_req_data_i,
    // dequeue side (bus controller)
    output logic                          io_q_bus_ctrl_req_vld_o,
    input  logic                          bus_ctrl_io_q_rdy_i,
    output logic                          io_q_bus_ctrl_req_load_or_store_o,
    output logic                          io_q_bus_ctrl_req_is_fence_o,
    output logic [ROB_INDEX_WIDTH-1:0]    io_q_bus_ctrl_req_rob_index_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] io_q_bus_ctrl_req_rd_addr_o,
    output logic [STU_OP_WIDTH-1:0]       io_q_bus_ctrl_req_opcode_o,
    output logic [PHYSICAL_ADDR_LEN-1:0]  io_q_bus_ctrl_req_paddr_o,
    output logic [XLEN-1:0]               io_q_bus_ctrl_req_data_o,
    input  logic                          bus_ctrl_io_q_done_i,
    // fence retirement and status
    output logic                          io_q_fence_done_o,
    output logic [ROB_INDEX_WIDTH-1:0]    io_q_fence_rob_index_o,
    output logic [$clog2(DEPTH):0]        io_q_cnt_o
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [c_IDX_W:0]              r_wr_ptr;
    logic [c_IDX_W:0]              r_rd_ptr;
    logic [1:0]                    r_outstanding;

    logic                          r_ls       [DEPTH];
    logic                          r_fence    [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]    r_rob      [DEPTH];
    logic [PHY_REG_ADDR_WIDTH-1:0] r_rd_addr  [DEPTH];
    logic [STU_OP_WIDTH-1:0]       r_opcode   [DEPTH];
    logic [PHYSICAL_ADDR_LEN-1:0]  r_paddr    [DEPTH];
    logic [XLEN-1:0]               r_data     [DEPTH];

    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_head_fence;
    logic               w_enq;
    logic               w_deq;
    logic               w_fence_pop;
    logic               w_pop;
    logic               w_out_dec;

    assign w_wr_idx     = r_wr_ptr[c_IDX_W-1:0];
    assign w_rd_idx     = r_rd_ptr[c_IDX_W-1:0];
    assign w_full       = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_head_fence = r_fence[w_rd_idx];

    assign io_q_lsq_rdy_o          = ~w_full;
    assign io_q_bus_ctrl_req_vld_o = ~w_empty & ~w_head_fence;

    // A flush drops every same-cycle pointer/counter update.
    assign w_enq       = lsq_io_q_req_vld_i & io_q_lsq_rdy_o & ~flush;
    assign w_deq       = io_q_bus_ctrl_req_vld_o & bus_ctrl_io_q_rdy_i & ~flush;
    assign w_fence_pop = ~w_empty & w_head_fence & (r_outstanding == 2'd0) & ~flush;
    assign w_pop       = w_deq | w_fence_pop;
    assign w_out_dec   = bus_ctrl_io_q_done_i & (r_outstanding != 2'd0);

    assign io_q_fence_done_o      = w_fence_pop;
    assign io_q_fence_rob_index_o = w_fence_pop ? r_rob[w_rd_idx] : '0;

    assign io_q_bus_ctrl_req_load_or_store_o = r_ls[w_rd_idx];
    assign io_q_bus_ctrl_req_is_fence_o      = w_head_fence;
    assign io_q_bus_ctrl_req_rob_index_o     = r_rob[w_rd_idx];
    assign io_q_bus_ctrl_req_rd_addr_o       = r_rd_addr[w_rd_idx];
    assign io_q_bus_ctrl_req_opcode_o        = r_opcode[w_rd_idx];
    assign io_q_bus_ctrl_req_paddr_o         = r_paddr[w_rd_idx];
    assign io_q_bus_ctrl_req_data_o          = r_data[w_rd_idx];

    assign io_q_cnt_o = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= 2'd0;
        end else if (flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= 2'd0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_deq, w_out_dec})
                2'b10:   r_outstanding <= r_outstanding + 2'd1;
                2'b01:   r_outstanding <= r_outstanding - 2'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ls[i]      <= 1'b0;
                r_fence[i]   <= 1'b0;
                r_rob[i]     <= '0;
                r_rd_addr[i] <= '0;
                r_opcode[i]  <= '0;
                r_paddr[i]   <= '0;
                r_data[i]    <= '0;
            end
        end else if (w_enq) begin
            r_ls[w_wr_idx]      <= lsq_io_q_req_load_or_store_i;
            r_fence[w_wr_idx]   <= lsq_io_q_req_is_fence_i;
            r_rob[w_wr_idx]     <= lsq_io_q_req_rob_index_i;
            r_rd_addr[w_wr_idx] <= lsq_io_q_req_rd_addr_i;
            r_opcode[w_wr_idx]  <= lsq_io_q_req_opcode_i;
            r_paddr[w_wr_idx]   <= lsq_io_q_req_paddr_i;
            r_data[w_wr_idx]    <= lsq_io_q_req_data_i;
        end
    end

    // A done pulse with nothing outstanding is a bus controller protocol error.
    always @(posedge clk) begin
        if (!rst && !flush && bus_ctrl_io_q_done_i) begin
            assert (r_outstanding != 2'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_io_req_queue.sv
// ============================================================================
//  Module      : tb_lsu_io_req_queue
//  Description : Directed self-checking bench for lsu_io_req_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_io_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        enq_vld;
    logic        enq_rdy;
    logic        enq_ls;
    logic        enq_fence;
    logic [5:0]  enq_rob;
    logic [5:0]  enq_rd;
    logic [4:0]  enq_op;
    logic [55:0] enq_paddr;
    logic [63:0] enq_data;
    logic        bus_vld;
    logic        bus_rdy;
    logic        bus_ls;
    logic        bus_fence;
    logic [5:0]  bus_rob;
    logic [5:0]  bus_rd;
    logic [4:0]  bus_op;
    logic [55:0] bus_paddr;
    logic [63:0] bus_data;
    logic        bus_done;
    logic        fence_done;
    logic [5:0]  fence_rob;
    logic [2:0]  cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lsu_io_req_queue dut (
        .clk                               (clk),
        .rst                               (rst),
        .flush                             (flush),
        .lsq_io_q_req_vld_i                (enq_vld),
        .io_q_lsq_rdy_o                    (enq_rdy),
        .lsq_io_q_req_load_or_store_i      (enq_ls),
        .lsq_io_q_req_is_fence_i           (enq_fence),
        .lsq_io_q_req_rob_index_i          (enq_rob),
        .lsq_io_q_req_rd_addr_i            (enq_rd),
        .lsq_io_q_req_opcode_i             (enq_op),
        .lsq_io_q_req_paddr_i              (enq_paddr),
        .lsq_io_q_req_data_i               (enq_data),
        .io_q_bus_ctrl_req_vld_o           (bus_vld),
        .bus_ctrl_io_q_rdy_i               (bus_rdy),
        .io_q_bus_ctrl_req_load_or_store_o (bus_ls),
        .io_q_bus_ctrl_req_is_fence_o      (bus_fence),
        .io_q_bus_ctrl_req_rob_index_o     (bus_rob),
        .io_q_bus_ctrl_req_rd_addr_o       (bus_rd),
        .io_q_bus_ctrl_req_opcode_o        (bus_op),
        .io_q_bus_ctrl_req_paddr_o         (bus_paddr),
        .io_q_bus_ctrl_req_data_o          (bus_data),
        .bus_ctrl_io_q_done_i              (bus_done),
        .io_q_fence_done_o                 (fence_done),
        .io_q_fence_rob_index_o            (fence_rob),
        .io_q_cnt_o                        (cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request on the LSQ side; the caller ticks.
    task automatic drive_req(input logic ls, input logic fence, input logic [5:0] rob);
        enq_vld   = 1'b1;
        enq_ls    = ls;
        enq_fence = fence;
        enq_rob   = rob;
        enq_rd    = rob + 6'd1;
        enq_op    = 5'(rob);
        enq_paddr = 56'(rob) << 8;
        enq_data  = {32'hCAFE_0000, 26'd0, rob};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bus_rdy = 1'b0; bus_done = 1'b0;
        enq_vld = 1'b0; enq_ls = 1'b0; enq_fence = 1'b0; enq_rob = '0;
        enq_rd = '0; enq_op = '0; enq_paddr = '0; enq_data = '0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check_eq("rst_rdy",   enq_rdy,    1);
        check_eq("rst_vld",   bus_vld,    0);
        check_eq("rst_fdone", fence_done, 0);
        check_eq("rst_cnt",   cnt,        0);
        check_eq("rst_paddr", bus_paddr,  0);
        check_eq("rst_data",  bus_data,   0);

        // fill with 4 loads while the bus controller stalls
        for (int i = 1; i <= 4; i++) begin
            drive_req(1'b0, 1'b0, 6'(i));
            tick();
        end
        check_eq("full_cnt", cnt,     4);
        check_eq("full_rdy", enq_rdy, 0);
        drive_req(1'b0, 1'b0, 6'd9);
        tick();
        enq_vld = 1'b0;
        check_eq("full_no_enq_cnt", cnt, 4);
        check_eq("head1_paddr", bus_paddr, 56'h100);
        check_eq("head1_rd",    bus_rd,    2);

        // drain in order; the controller completes one per cycle after the first
        bus_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_done = (i > 1);
            check_eq("drain_vld", bus_vld, 1);
            check_eq("drain_rob", bus_rob, 64'(i));
            tick();
        end
        bus_rdy = 1'b0;
        check_eq("drain_cnt", cnt, 0);
        check_eq("drain_vld_off", bus_vld, 0);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;

        // store rob 5 issued, fence rob 6 waits for its completion
        drive_req(1'b1, 1'b0, 6'd5);
        bus_rdy = 1'b1;
        tick();
        check_eq("st_vld", bus_vld, 1);
        check_eq("st_ls",  bus_ls,  1);
        check_eq("st_rob", bus_rob, 5);
        drive_req(1'b0, 1'b1, 6'd6);
        tick();
        enq_vld = 1'b0;
        bus_rdy = 1'b0;
        check_eq("f6_vld",       bus_vld,    0);
        check_eq("f6_is_fence",  bus_fence,  1);
        check_eq("f6_wait",      fence_done, 0);
        check_eq("f6_wait_rob",  fence_rob,  0);
        tick();
        check_eq("f6_wait2", fence_done, 0);
        bus_done = 1'b1;
        check_eq("f6_same_cycle_done", fence_done, 0);
        tick();
        bus_done = 1'b0;
        check_eq("f6_done", fence_done, 1);
        check_eq("f6_rob",  fence_rob,  6);
        tick();
        check_eq("f6_cnt",    cnt,        0);
        check_eq("f6_dropped", fence_done, 0);

        // fence into an idle queue retires the next cycle
        drive_req(1'b0, 1'b1, 6'd7);
        check_eq("f7_pre", fence_done, 0);
        tick();
        enq_vld = 1'b0;
        check_eq("f7_done", fence_done, 1);
        check_eq("f7_rob",  fence_rob,  7);
        check_eq("f7_vld",  bus_vld,    0);
        tick();
        check_eq("f7_cnt",  cnt,        0);

        // 3 queued, 1 outstanding, flush with a simultaneous enqueue
        for (int i = 10; i <= 13; i++) begin
            drive_req(1'b0, 1'b0, 6'(i));
            tick();
        end
        enq_vld = 1'b0;
        bus_rdy = 1'b1;
        tick();
        bus_rdy = 1'b0;
        check_eq("pre_flush_cnt", cnt, 3);
        check_eq("pre_flush_rob", bus_rob, 11);
        flush = 1'b1;
        drive_req(1'b0, 1'b0, 6'd14);
        check_eq("flush_fdone", fence_done, 0);
        tick();
        flush = 1'b0;
        enq_vld = 1'b0;
        check_eq("flush_cnt", cnt,     0);
        check_eq("flush_vld", bus_vld, 0);
        check_eq("flush_rdy", enq_rdy, 1);
        drive_req(1'b0, 1'b1, 6'd15);
        tick();
        enq_vld = 1'b0;
        check_eq("f15_done", fence_done, 1);
        check_eq("f15_rob",  fence_rob,  15);
        tick();

        // stream 10 entries with simultaneous enqueue and dequeue
        drive_req(1'b0, 1'b0, 6'd20);
        tick();
        bus_rdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i < 10) drive_req(1'b0, 1'b0, 6'(20 + i));
            else        enq_vld = 1'b0;
            bus_done = (i > 1);
            check_eq("stream_cnt", cnt,     1);
            check_eq("stream_rob", bus_rob, 64'(20 + i - 1));
            tick();
        end
        bus_rdy = 1'b0;
        check_eq("stream_end_cnt", cnt, 0);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;

        // asynchronous reset mid-cycle
        for (int i = 30; i <= 31; i++) begin
            drive_req(1'b0, 1'b0, 6'(i));
            tick();
        end
        enq_vld = 1'b0;
        check_eq("arst_pre_cnt", cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_cnt",   cnt,     0);
        check_eq("arst_vld",   bus_vld, 0);
        check_eq("arst_rdy",   enq_rdy, 1);
        check_eq("arst_rob",   bus_rob, 0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_cnt", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
